mem_initiator: RTL
==================

# mem_initiator

Single-outstanding initiator for the peripheral memory bus, the requesting end of the mem_valid/mem_ready protocol that GPIO and the other memory-mapped peripherals answer on. It takes one read or write command at a time on a valid/ready command port and drives it onto the bus. It holds the request until the responder raises mem_ready or a timeout expires, then returns read data and status on a valid/ready response port. It sits between an upstream controller (debug bridge, boot sequencer) and the peripheral address decoder.

## Interface
- TIMEOUT, 16: cycles mem_valid may stay high without mem_ready before abort; legal range 1..255.
- clk  in  1  single clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timed out.
- busy  out  1  high in every state except IDLE.
- mem_valid  out  1  bus request.
- mem_ready  in  1  responder acknowledge, registered one cycle after mem_valid.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_we  out  1  bus write strobe.
- mem_rdata  in  32  responder read data; valid only while mem_valid is high.

## Operation
- States: IDLE, REQ, RSP, GAP. Reset enters IDLE.
- IDLE: cmd_ready = 1, driven combinationally from state. On accept, latch addr/wdata/we into mem_addr/mem_wdata/mem_we, clear the timeout counter, go to REQ.
- REQ: mem_valid = 1, and mem_we = latched cmd_we. Addr, wdata and we stay stable for the whole state.
  - mem_ready = 1 at an edge: capture mem_rdata (read) or 0 (write) into rsp_rdata, set rsp_err = 0, go to RSP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set rsp_rdata = 0 and rsp_err = 1, go to RSP.
- RSP: rsp_valid = 1, mem_valid = 0, mem_we = 0. rsp_rdata and rsp_err stay stable until consumed. On rsp_ready, go to GAP.
- GAP: one mandatory idle cycle, then IDLE. Responders register mem_ready from mem_valid, so mem_ready stays high one cycle after mem_valid falls. That stale ready must never complete a following request.
- mem_ready is ignored in every state except REQ.
- mem_we is high only in REQ with a latched write. Responders decode writes from we alone, so a stray we corrupts registers.
- mem_addr and mem_wdata keep their last values outside REQ. They are not cleared.
- Counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.

## Timing
- Reset values: cmd_ready = 1 (IDLE), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, mem_valid = 0, mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Command accepted at edge N:
  - mem_valid is high from N to N+2.
  - A registered responder raises mem_ready after edge N+1; data is captured at edge N+2.
  - rsp_valid is high after N+2.
  - If rsp_ready is already high, the response is consumed at N+3, GAP runs N+3..N+4, and cmd_ready is high again after N+4.
- Minimum command-to-command spacing is 5 cycles.
- Timeout: with mem_ready stuck low, rsp_valid (err = 1) rises after edge N+TIMEOUT. mem_valid is high for exactly TIMEOUT cycles.
- mem_ready arriving in the same cycle the counter hits TIMEOUT: success wins, rsp_err = 0.
- Reset mid-operation, asserted in any state, forces all outputs to their reset values asynchronously. The in-flight command and response are discarded.

## Test plan
- Write: cmd we=1, addr 0x0000_0004, wdata 0x5 to a registered responder -> mem_we high only during the 2 REQ cycles; rsp_valid after edge N+2 with rdata 0, err 0.
- Read: responder returns 0xA5A5_0003 at addr 0x8 -> rsp_rdata = 0xA5A5_0003, err 0, mem_valid low once RSP is entered.
- Back-to-back: second command waiting with cmd_valid held -> it is accepted 5 cycles after the first; the stale mem_ready during GAP does not complete it; both responses are correct and in order.
- Timeout: TIMEOUT = 4, mem_ready tied low -> mem_valid high exactly 4 cycles, rsp_err = 1, rsp_rdata = 0; the next command to a live responder succeeds.
- Response backpressure: rsp_ready low for 10 cycles -> rsp_valid/rdata held stable, cmd_ready = 0, mem_valid = 0 throughout.
- Reset in REQ: resetn pulsed low mid-request -> mem_valid/mem_we drop without waiting for a clock, no rsp_valid follows, cmd_ready = 1 after release.

Source files
------------

// File: rtl/mem_initiator.sv
// -----------------------------------------------------------------------------
// mem_initiator
//
// Single-outstanding initiator for the peripheral memory bus. It takes one
// read or write command at a time, drives it onto the mem_valid/mem_ready bus,
// and returns the read data and status on a response port.
//
// Handshake semantics (command and response ports alike): a transfer happens
// at a rising edge where valid && ready are both high. A producer holds valid
// and its payload stable until that edge. ready may depend on state only,
// never combinationally on the partner's valid.
//
// Ports
//   clk, resetn          clock (rising edge) and asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_we, cmd_addr, cmd_wdata payload
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_err payload
//   busy                 high whenever the FSM is not in IDLE
//   mem_valid/mem_ready  bus request / registered responder acknowledge
//   mem_addr, mem_wdata  bus address and write data (hold last value)
//   mem_we               bus write strobe, only high in REQ for a write
//   mem_rdata            responder read data, meaningful while mem_valid
//   dbg_state            current FSM state (0 IDLE, 1 REQ, 2 RSP, 3 GAP)
// -----------------------------------------------------------------------------
module mem_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          we_q;
  logic          cmd_fire;
  logic          req_ok;
  logic          req_tmo;

  // Saturating increment: the counter never wraps back below TIMEOUT.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  assign cmd_fire = (state == S_IDLE) && cmd_valid;
  // A responder acknowledge wins over a timeout landing on the same edge.
  assign req_ok   = (state == S_REQ) && mem_ready;
  assign req_tmo  = (state == S_REQ) && !mem_ready && (cnt_inc == CNT_MAX);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = S_REQ;
          cnt_nxt   = '0;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_nxt = S_RSP;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_MAX) state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_nxt = S_GAP;
      end
      // GAP exists so that the responder's registered ready, which lingers
      // one cycle after mem_valid falls, cannot complete the next request.
      S_GAP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state; reset forces them asynchronously via state.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    mem_valid = (state == S_REQ);
    mem_we    = (state == S_REQ) && we_q;
    rsp_valid = (state == S_RSP);
    dbg_state = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath: command latch and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        mem_addr  <= cmd_addr;
        mem_wdata <= cmd_wdata;
        we_q      <= cmd_we;
      end
      if (req_ok) begin
        rsp_rdata <= we_q ? 32'd0 : mem_rdata;
        rsp_err   <= 1'b0;
      end else if (req_tmo) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule
